// File: rtl/aes_block_packer.sv
// aes_block_packer: packs a narrow valid/ready word stream into 128-bit AES
// blocks for aes_ctr. The short final block is padded and carries its
// valid byte count.
// Optional feature: define AES_PACK_PKCS7_EN to replace zero padding with
// PKCS7 padding, including the extra pad block after a block-aligned message end.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; a source holds its payload stable while valid && !ready.
`default_nettype none

module aes_block_packer #(
    parameter int IN_BYTES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [8*IN_BYTES-1:0]     in_data_i,
    input  logic [$clog2(IN_BYTES):0] in_bytes_i,
    input  logic                      in_last_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [127:0]              blk_o,
    output logic [4:0]                blk_bytes_o,
    output logic                      blk_last_o,
    output logic                      blk_valid_o,
    input  logic                      blk_ready_i
);

    localparam int WPB   = 16 / IN_BYTES;
    localparam int CW    = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int WBITS = 8 * IN_BYTES;

    typedef enum logic {
        FILL = 1'b0,
        PAD  = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [127:0]   acc_q;
    logic [127:0]   acc_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;

    logic [WBITS-1:0] word_m;
    logic [127:0]     placed;
    logic [127:0]     merged;
    logic [4:0]       tot;
    logic             slot_full;
    logic             accept;
    logic             out_free;
    logic             out_hs;

    logic             load;
    logic [127:0]     ld_data;
    logic [4:0]       ld_bytes;
    logic             ld_last;

`ifdef AES_PACK_PKCS7_EN
    logic [127:0]     padded;
    logic [7:0]       pad_byte;
`endif

    // Input is taken only in FILL and only when the output register can move.
    assign in_ready_o = (state_q == FILL) && !(blk_valid_o && !blk_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign out_hs     = blk_valid_o && blk_ready_i;
    assign out_free   = !blk_valid_o || blk_ready_i;
    assign slot_full  = (cnt_q == CW'(WPB - 1));

    // Zero the bytes of a last word beyond its valid count, then place the
    // word into its accumulator slot (slot 0 at the top of the block).
    always_comb begin
        word_m = in_data_i;
        for (int b = 0; b < IN_BYTES; b++) begin
            if (in_last_i && (b >= int'(in_bytes_i))) begin
                word_m[WBITS-8-8*b +: 8] = 8'h00;
            end
        end
        placed = (128'(word_m) << (128 - WBITS)) >> (int'(cnt_q) * WBITS);
        merged = acc_q | placed;
        tot    = in_last_i ? 5'(int'(cnt_q) * IN_BYTES + int'(in_bytes_i)) : 5'd16;
    end

`ifdef AES_PACK_PKCS7_EN
    // PKCS7 fill: every byte past the valid total carries the pad length.
    always_comb begin
        pad_byte = 8'(16 - int'(tot));
        padded   = merged;
        for (int i = 0; i < 16; i++) begin
            if (i >= int'(tot)) begin
                padded[127-8*i -: 8] = pad_byte;
            end
        end
    end
`endif

    // Next state, accumulator update and output-register load decision.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        ld_data  = merged;
        ld_bytes = 5'd16;
        ld_last  = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (!slot_full && !in_last_i) begin
                        acc_d = merged;
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        acc_d = '0;
                        cnt_d = '0;
`ifdef AES_PACK_PKCS7_EN
                        if (!in_last_i) begin
                            load = 1'b1;
                        end else if (tot == 5'd16) begin
                            // Block-aligned end: data block is not the last one.
                            load    = 1'b1;
                            state_d = PAD;
                        end else if (tot == 5'd0) begin
                            // Nothing left to send but the full pad block.
                            state_d = PAD;
                        end else begin
                            load    = 1'b1;
                            ld_data = padded;
                            ld_last = 1'b1;
                        end
`else
                        // An empty tail on a block boundary produces no block.
                        if (!(in_last_i && (tot == 5'd0))) begin
                            load     = 1'b1;
                            ld_bytes = tot;
                            ld_last  = in_last_i;
                        end
`endif
                    end
                end
            end
            PAD: begin
                if (out_free) begin
                    load     = 1'b1;
                    ld_data  = {16{8'h10}};
                    ld_bytes = 5'd16;
                    ld_last  = 1'b1;
                    state_d  = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulator and word counter; reset discards any partial block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Output register: loads a finished block, holds while stalled, and
    // drops valid after a handshake unless a new block arrives that edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_o       <= '0;
            blk_bytes_o <= '0;
            blk_last_o  <= 1'b0;
            blk_valid_o <= 1'b0;
        end else if (load) begin
            blk_o       <= ld_data;
            blk_bytes_o <= ld_bytes;
            blk_last_o  <= ld_last;
            blk_valid_o <= 1'b1;
        end else if (out_hs) begin
            blk_valid_o <= 1'b0;
        end
    end

endmodule

`default_nettype wire
